// File: rtl/led_pattern_ctrl_pkg.sv
// Shared encodings for the LED pattern controller: modes, control states and
// the LED pattern constants, plus helpers to validate a mode and render a pattern.
package led_pattern_ctrl_pkg;

  typedef enum logic [2:0] {
    MODE_OFF       = 3'd0,
    MODE_FLOW_L    = 3'd1,
    MODE_FLOW_R    = 3'd2,
    MODE_PING_PONG = 3'd3,
    MODE_BLINK     = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

  localparam logic [7:0] LED_NONE = 8'h00;
  localparam logic [7:0] LED_LSB  = 8'h01;
  localparam logic [7:0] LED_MSB  = 8'h80;
  localparam logic [7:0] LED_ALL  = 8'hFF;

  function automatic logic mode_is_legal(input logic [2:0] m);
    return (m <= 3'd4);
  endfunction

  // pos is the position within the pattern: bit index for the flowing modes,
  // phase (bit 0) for blink.
  function automatic logic [7:0] pattern_of(input mode_e m, input logic [2:0] pos);
    logic [7:0] p;
    case (m)
      MODE_FLOW_L, MODE_PING_PONG: p = LED_LSB << pos;
      MODE_FLOW_R:                 p = LED_MSB >> pos;
      MODE_BLINK:                  p = pos[0] ? LED_NONE : LED_ALL;
      default:                     p = LED_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_pattern_ctrl_step_timer.sv
// Step timer: holds the step period and a free-running cycle counter that
// produces a terminal-count pulse once per period while enabled.
module led_step_timer #(
  parameter int unsigned DEFAULT_PERIOD = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] period_i,
  input  logic        clear_i,
  input  logic        en_i,
  output logic        tc_o
);

  logic [31:0] period_q;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // A load or clear in the same cycle as terminal count suppresses the pulse.
  assign tc_o = en_i && !load_i && !clear_i && (cnt_q == (period_q - 32'd1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i || clear_i) begin
      cnt_d = 32'd0;
    end else if (en_i) begin
      cnt_d = tc_o ? 32'd0 : cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= 32'(DEFAULT_PERIOD);
      cnt_q    <= 32'd0;
    end else begin
      if (load_i) begin
        period_q <= period_i;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: config handshake, IDLE/RUN/PAUSED control and the
// pattern generator; step timing comes from led_step_timer.
module led_pattern_ctrl
  import led_pattern_ctrl_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ     = 50000000,
  parameter int unsigned DEFAULT_PERIOD = CLOCK_FREQ / 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_mode,
  input  logic [31:0] cfg_period,
  input  logic        pause,
  output logic [7:0]  led,
  output logic        step,
  output logic        cfg_err
);

  state_e     state_q;
  mode_e      mode_q;
  logic [2:0] pos_q;
  logic [2:0] pos_d;
  logic       dir_q;
  logic       dir_d;
  logic [7:0] led_q;
  logic       step_q;
  logic       err_q;
  logic       ready_q;

  logic       accept;
  logic       cfg_ok;
  logic       load;
  logic       run_en;
  logic       tc;

  assign accept = cfg_valid && ready_q;
  assign cfg_ok = mode_is_legal(cfg_mode) && (cfg_period != 32'd0);
  assign load   = accept && cfg_ok;
  // Live pause gates counting so the freeze takes effect in the cycle pause rises.
  assign run_en = (state_q != ST_IDLE) && !pause && !load;

  led_step_timer #(
    .DEFAULT_PERIOD(DEFAULT_PERIOD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .period_i (cfg_period),
    .clear_i  (state_q == ST_IDLE),
    .en_i     (run_en),
    .tc_o     (tc)
  );

  // Ping-pong bounces between bit 0 and bit 7, showing each end once per sweep.
  always_comb begin
    pos_d = pos_q + 3'd1;
    dir_d = dir_q;
    if (mode_q == MODE_PING_PONG) begin
      if (!dir_q) begin
        if (pos_q == 3'd6) dir_d = 1'b1;
      end else begin
        pos_d = pos_q - 3'd1;
        if (pos_q == 3'd1) dir_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_OFF;
      pos_q   <= 3'd0;
      dir_q   <= 1'b0;
      led_q   <= LED_NONE;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= !accept;
      err_q   <= accept && !cfg_ok;
      step_q  <= 1'b0;
      if (load) begin
        mode_q <= mode_e'(cfg_mode);
        pos_q  <= 3'd0;
        dir_q  <= 1'b0;
        led_q  <= pattern_of(mode_e'(cfg_mode), 3'd0);
        if (cfg_mode == MODE_OFF) begin
          state_q <= ST_IDLE;
        end else begin
          state_q <= pause ? ST_PAUSED : ST_RUN;
        end
      end else begin
        if (state_q != ST_IDLE) begin
          state_q <= pause ? ST_PAUSED : ST_RUN;
        end
        if (tc) begin
          pos_q  <= pos_d;
          dir_q  <= dir_d;
          led_q  <= pattern_of(mode_q, pos_d);
          step_q <= 1'b1;
        end
      end
    end
  end

  assign cfg_ready = ready_q;
  assign led       = led_q;
  assign step      = step_q;
  assign cfg_err   = err_q;

endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter DEFAULT_PERIOD, default CLOCK_FREQ/2, meaning the step period in clk cycles used after reset (0.5 s).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cfg_valid  input  1  configuration request.
REQ-006 cfg_ready  output  1  block can accept configuration.
REQ-007 cfg_mode  input  3  requested pattern mode.
REQ-008 cfg_period  input  32  requested step period in clk cycles.
REQ-009 pause  input  1  level; freezes stepping while high.
REQ-010 led  output  8  LED drive, registered; 1 = on.
REQ-011 step  output  1  one-cycle pulse on every pattern advance.
REQ-012 cfg_err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-013 Modes SHALL be: 0 OFF (led 0x00), 1 FLOW_L (0x01,0x02..0x80, wraps to 0x01), 2 FLOW_R (0x80,0x40..0x01, wraps to 0x80), 3 PING_PONG (0x01..0x80..0x01; each end shown once per sweep, 14-step cycle), 4 BLINK (0xFF,0x00 alternating); 5-7 reserved.
REQ-014 Handshake: request accepted in the cycle cfg_valid && cfg_ready is high; cfg_mode/cfg_period are sampled only in that cycle.
REQ-015 cfg_ready SHALL be low for exactly the one cycle after an acceptance or rejection, otherwise high outside reset.
REQ-016 Reserved mode or cfg_period == 0 SHALL be rejected: cfg_err pulses in the next cycle; mode, period, counter and led are unchanged.
REQ-017 On acceptance at cycle N: period loaded, cycle counter cleared, position/direction reset; led shows the mode's first pattern from cycle N+1.
REQ-018 Cycle counter SHALL count 0..period-1 while in RUN; at period-1 it returns to 0, the pattern advances, and step pulses in the same cycle the new led value appears.
REQ-019 cfg_period == 1 SHALL advance the pattern every cycle.
REQ-020 State machine: IDLE (mode OFF, counter held at 0), RUN (mode 1-4, pause low), PAUSED (mode 1-4, pause high); RUN<->PAUSED follows pause; any state -> IDLE on accepted mode 0; IDLE -> RUN/PAUSED on accepted mode 1-4.
REQ-021 In PAUSED, counter, led and position SHALL hold; on return to RUN, counting resumes from the held count.
REQ-022 Acceptance in the same cycle as a counter terminal count SHALL win: no step pulse, no advance, new configuration applied.
REQ-023 Accepting the already active mode SHALL restart it (counter cleared, first pattern).
REQ-024 Counter compare SHALL be full 32-bit unsigned; no truncation of cfg_period.
REQ-025 step SHALL never pulse in IDLE or PAUSED.

Reset
REQ-026 While rst is high at a clk edge: led = 0x00 registered on that edge, step = 0, cfg_err = 0, cfg_ready = 0, state IDLE, period = DEFAULT_PERIOD, counter = 0, position and direction cleared.
REQ-027 cfg_ready SHALL rise in the first cycle after rst deasserts.
REQ-028 Reset asserted mid-pattern or mid-handshake SHALL override all other activity; a request presented in the reset cycle is discarded.

Structure
REQ-029 A shared package SHALL hold the mode encodings (OFF, FLOW_L, FLOW_R, PING_PONG, BLINK), the state encodings (IDLE, RUN, PAUSED) and the pattern constants 0x01/0x80/0xFF.
REQ-030 A sub-module led_step_timer SHALL contain the period register, cycle counter and terminal-count pulse, with load, clear and enable inputs.
REQ-031 Top level SHALL hold the handshake, state machine and pattern generator.

Verification
REQ-032 Reset release, then mode 1 with period 4 -> led 0x01 one cycle after accept; 0x02 four cycles later; after 0x80, next step shows 0x01; step pulses every 4 cycles.
REQ-033 Mode 3, period 1 -> led sequence 0x01,0x02..0x80,0x40..0x02,0x01,0x02 on consecutive cycles; 0x80 appears once per sweep.
REQ-034 Mode 4, period 3, pause high for 5 cycles mid-run -> led and step frozen for those cycles; next toggle 3 minus the count held at pause cycles after pause falls.
REQ-035 Request mode 6, then mode 2 with period 0 -> cfg_err pulses once per request; led, mode and period unchanged; cfg_ready low one cycle after each request.
REQ-036 Accept mode 2 in the same cycle the mode 1 counter hits terminal count -> no step pulse that cycle; led = 0x80 next cycle.
REQ-037 Assert rst during mode 1 at led 0x10 -> led 0x00, cfg_ready 0 on that edge; after release the period is DEFAULT_PERIOD and state is IDLE.
